axil_mitm_wr_pipe: RTL and testbench

AXIL_MITM_WR_PIPE -- requirements
Module: axil_mitm_wr_pipe

---
 rtl/axil_pkg.sv | 12 +
 rtl/axil_mitm_order_fifo.sv | 54 +++++
 rtl/axil_mitm_wr_pipe.sv | 121 ++++++++++++
 tb/tb_axil_mitm_wr_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI-lite response codes and order-queue tag encoding
package axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    typedef enum logic {
        TAG_FWD = 1'b0,
        TAG_BLK = 1'b1
    } order_tag_e;

endpackage

// File: rtl/axil_mitm_order_fifo.sv
// rtl/axil_mitm_order_fifo.sv - 1-bit order queue; a push is taken while full if a pop happens in the same cycle
module axil_mitm_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         push_data,
    input  logic                         pop,
    output logic                         pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/axil_mitm_wr_pipe.sv
// rtl/axil_mitm_wr_pipe.sv - AXI-lite write pass-through with in-order responses; address-window blocking under AXIL_MITM_WR_BLOCK_EN
module axil_mitm_wr_pipe #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic [ADDR_WIDTH-1:0]                s_axil_awaddr,
    input  logic [2:0]                           s_axil_awprot,
    input  logic                                 s_axil_awvalid,
    output logic                                 s_axil_awready,
    input  logic [DATA_WIDTH-1:0]                s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]                s_axil_wstrb,
    input  logic                                 s_axil_wvalid,
    output logic                                 s_axil_wready,
    output logic [1:0]                           s_axil_bresp,
    output logic                                 s_axil_bvalid,
    input  logic                                 s_axil_bready,

    output logic [ADDR_WIDTH-1:0]                m_axil_awaddr,
    output logic [2:0]                           m_axil_awprot,
    output logic                                 m_axil_awvalid,
    input  logic                                 m_axil_awready,
    output logic [DATA_WIDTH-1:0]                m_axil_wdata,
    output logic [STRB_WIDTH-1:0]                m_axil_wstrb,
    output logic                                 m_axil_wvalid,
    input  logic                                 m_axil_wready,
    input  logic [1:0]                           m_axil_bresp,
    input  logic                                 m_axil_bvalid,
    output logic                                 m_axil_bready,

    input  logic [ADDR_WIDTH-1:0]                block_base,
    input  logic [ADDR_WIDTH-1:0]                block_mask,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

    import axil_pkg::*;

    logic q_full;
    logic q_empty;
    logic q_head;
    logic head_blocked;
    logic is_blocked;
    logic s_b_free;
    logic blk_fire;
    logic pop;
    logic accept;

`ifdef AXIL_MITM_WR_BLOCK_EN
    assign is_blocked   = (block_mask != '0) &&
                          ((s_axil_awaddr & block_mask) == (block_base & block_mask));
    assign head_blocked = (q_head == TAG_BLK);
`else
    logic unused_block;
    assign unused_block = ^{block_base, block_mask, q_head};
    assign is_blocked   = 1'b0;
    assign head_blocked = 1'b0;
`endif

    // A response may be loaded only when the slave b register is empty or draining this cycle.
    assign s_b_free       = !s_axil_bvalid || s_axil_bready;
    assign m_axil_bready  = !rst && !q_empty && !head_blocked && s_b_free;
    assign blk_fire       = !rst && !q_empty && head_blocked && s_b_free;
    assign pop            = (m_axil_bvalid && m_axil_bready) || blk_fire;

    assign accept         = !rst && s_axil_awvalid && s_axil_wvalid &&
                            (!q_full || pop) && !m_axil_awvalid && !m_axil_wvalid;
    assign s_axil_awready = accept;
    assign s_axil_wready  = accept;

    axil_mitm_order_fifo #(
        .DEPTH     (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (is_blocked),
        .pop       (pop),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (outstanding)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= AXIL_RESP_OKAY;
        end else begin
            if (accept && !is_blocked) begin
                m_axil_awvalid <= 1'b1;
                m_axil_wvalid  <= 1'b1;
            end else begin
                if (m_axil_awready) m_axil_awvalid <= 1'b0;
                if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
            end

            if (pop) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= head_blocked ? AXIL_RESP_SLVERR : m_axil_bresp;
            end else if (s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !is_blocked) begin
            m_axil_awaddr <= s_axil_awaddr;
            m_axil_awprot <= s_axil_awprot;
            m_axil_wdata  <= s_axil_wdata;
            m_axil_wstrb  <= s_axil_wstrb;
        end
    end

endmodule

// File: tb/tb_axil_mitm_wr_pipe.sv
// tb/tb_axil_mitm_wr_pipe.sv - randomized scoreboard bench for axil_mitm_wr_pipe
module tb_axil_mitm_wr_pipe;

    import axil_pkg::*;

    localparam int MO = 4;

`ifdef AXIL_MITM_WR_BLOCK_EN
    localparam bit BLK_EN = 1'b1;
`else
    localparam bit BLK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axil_awaddr;
    logic [2:0]  s_axil_awprot;
    logic        s_axil_awvalid, s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid, s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid, s_axil_bready;
    logic [31:0] m_axil_awaddr;
    logic [2:0]  m_axil_awprot;
    logic        m_axil_awvalid, m_axil_awready;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_wvalid, m_axil_wready;
    logic [1:0]  m_axil_bresp;
    logic        m_axil_bvalid, m_axil_bready;
    logic [31:0] block_base, block_mask;
    logic [2:0]  outstanding;

    always #5 clk = ~clk;

    axil_mitm_wr_pipe #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .block_base(block_base), .block_mask(block_mask), .outstanding(outstanding)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: writes still to present, expected master traffic, expected response order.
    wr_t        issue_q[$];
    wr_t        fwd_aw_q[$];
    wr_t        fwd_w_q[$];
    bit         order_q[$];
    logic [1:0] mresp_q[$];
    logic [1:0] got_q[$];

    int aw_rdy_pct, w_rdy_pct, sb_rdy_pct, b_delay_cfg;
    bit b_rand_delay, b_rand_resp, b_hold;
    int aw_done, w_done, b_issued, b_wait, accepted, cyc, last_mb_cyc;
    bit s_hs, mb_hs, sb_prev_valid, sb_prev_hs;
    logic [1:0] sb_prev_resp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit blocked(input logic [31:0] a, input logic [31:0] base, input logic [31:0] mask);
        return BLK_EN && (mask != 0) && ((a & mask) == (base & mask));
    endfunction

    task automatic add_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_t w;
        w.addr = a;
        w.prot = 3'($urandom_range(7));
        w.data = d;
        w.strb = s;
        issue_q.push_back(w);
    endtask

    task automatic clear_model();
        issue_q.delete(); fwd_aw_q.delete(); fwd_w_q.delete();
        order_q.delete(); mresp_q.delete();
        aw_done = 0; w_done = 0; b_issued = 0; b_wait = 0;
        s_hs = 0; mb_hs = 0; sb_prev_valid = 0; sb_prev_hs = 0;
    endtask

    task automatic step();
        wr_t        w;
        bit         blk;
        logic [1:0] exp;
        bit         is_new;
        @(negedge clk);
        if (s_hs) begin s_axil_awvalid = 0; s_axil_wvalid = 0; s_hs = 0; end
        if (mb_hs) begin
            m_axil_bvalid = 0; mb_hs = 0;
            b_wait = b_rand_delay ? int'($urandom_range(4)) : b_delay_cfg;
        end
        if (!s_axil_awvalid && issue_q.size() > 0) begin
            w = issue_q[0];
            s_axil_awaddr = w.addr; s_axil_awprot = w.prot;
            s_axil_wdata = w.data;  s_axil_wstrb = w.strb;
            s_axil_awvalid = 1; s_axil_wvalid = 1;
        end
        m_axil_awready = (int'($urandom_range(99)) < aw_rdy_pct);
        m_axil_wready  = (int'($urandom_range(99)) < w_rdy_pct);
        if (!m_axil_bvalid && !b_hold && (((aw_done < w_done) ? aw_done : w_done) > b_issued)) begin
            if (b_wait > 0) b_wait--;
            else begin
                m_axil_bvalid = 1;
                m_axil_bresp = b_rand_resp ? 2'($urandom_range(3)) : AXIL_RESP_OKAY;
            end
        end
        s_axil_bready = (int'($urandom_range(99)) < sb_rdy_pct);
        #1;
        cyc++;

        check("aw_w_ready_pair", s_axil_wready, s_axil_awready);
        is_new = s_axil_bvalid && (!sb_prev_valid || sb_prev_hs);
        if (sb_prev_valid && !sb_prev_hs) begin
            check("s_b_hold_valid", s_axil_bvalid, 1);
            check("s_b_hold_resp", s_axil_bresp, sb_prev_resp);
        end
        if (is_new && order_q.size() > 0 && !order_q[0])
            check("b_latency", cyc - last_mb_cyc, 1);

        if (s_axil_awvalid && s_axil_awready) begin
            w = issue_q.pop_front();
            blk = blocked(w.addr, block_base, block_mask);
            order_q.push_back(blk);
            if (!blk) begin fwd_aw_q.push_back(w); fwd_w_q.push_back(w); end
            accepted++;
            s_hs = 1;
        end
        if (m_axil_awvalid && m_axil_awready) begin
            check("m_aw_expected", fwd_aw_q.size() > 0, 1);
            if (fwd_aw_q.size() > 0) begin
                w = fwd_aw_q.pop_front();
                check("m_awaddr", m_axil_awaddr, w.addr);
                check("m_awprot", m_axil_awprot, w.prot);
            end
            aw_done++;
        end
        if (m_axil_wvalid && m_axil_wready) begin
            check("m_w_expected", fwd_w_q.size() > 0, 1);
            if (fwd_w_q.size() > 0) begin
                w = fwd_w_q.pop_front();
                check("m_wdata", m_axil_wdata, w.data);
                check("m_wstrb", m_axil_wstrb, w.strb);
            end
            w_done++;
        end
        if (m_axil_bvalid && m_axil_bready) begin
            mresp_q.push_back(m_axil_bresp);
            b_issued++;
            last_mb_cyc = cyc;
            mb_hs = 1;
        end
        if (s_axil_bvalid && s_axil_bready) begin
            check("s_b_expected", order_q.size() > 0, 1);
            if (order_q.size() > 0) begin
                blk = order_q.pop_front();
                exp = AXIL_RESP_SLVERR;
                if (!blk) begin
                    check("m_resp_available", mresp_q.size() > 0, 1);
                    exp = (mresp_q.size() > 0) ? mresp_q.pop_front() : 2'bxx;
                end
                check("s_bresp", s_axil_bresp, exp);
            end
            got_q.push_back(s_axil_bresp);
        end
        sb_prev_valid = s_axil_bvalid;
        sb_prev_hs    = s_axil_bvalid && s_axil_bready;
        sb_prev_resp  = s_axil_bresp;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((issue_q.size() > 0 || order_q.size() > 0) && n < max) begin
            step();
            n++;
        end
        check("drain_in_budget", n < max, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_bready = 0;
        m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_bresp = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_s_awready", s_axil_awready, 0);
        check("rst_s_wready", s_axil_wready, 0);
        check("rst_s_bvalid", s_axil_bvalid, 0);
        check("rst_s_bresp", s_axil_bresp, AXIL_RESP_OKAY);
        check("rst_m_awvalid", m_axil_awvalid, 0);
        check("rst_m_wvalid", m_axil_wvalid, 0);
        check("rst_m_bready", m_axil_bready, 0);
        check("rst_outstanding", outstanding, 0);
        s_axil_awvalid = 0; s_axil_wvalid = 0;
        clear_model();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic set_knobs(input int awp, input int wp, input int sbp, input int bdel, input bit rdel, input bit rresp);
        aw_rdy_pct = awp; w_rdy_pct = wp; sb_rdy_pct = sbp;
        b_delay_cfg = bdel; b_wait = bdel; b_rand_delay = rdel; b_rand_resp = rresp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout reached at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int a0, b0, n;
        logic [1:0] held;
        logic [31:0] base, mask;
        rst = 1;
        s_axil_awaddr = 0; s_axil_awprot = 0; s_axil_awvalid = 0;
        s_axil_wdata = 0; s_axil_wstrb = 0; s_axil_wvalid = 0; s_axil_bready = 0;
        m_axil_awready = 0; m_axil_wready = 0; m_axil_bresp = 0; m_axil_bvalid = 0;
        block_base = 0; block_mask = 0;
        accepted = 0; cyc = 0; last_mb_cyc = -10; b_hold = 0;
        clear_model();
        set_knobs(100, 100, 100, 0, 0, 0);
        do_reset();

        // Forwarded write with window disabled
        add_wr(32'h1000, 32'hDEAD_BEEF, 4'hF);
        got_q.delete();
        drain(50);
        check("fwd_resp_count", got_q.size(), 1);
        if (got_q.size() > 0) check("fwd_resp_okay", got_q[0], AXIL_RESP_OKAY);

        // Blocked write
        block_base = 32'h8000; block_mask = 32'hF000;
        add_wr(32'h8004, 32'h1234_5678, 4'h3);
        got_q.delete();
        drain(50);
        check("blk_resp_count", got_q.size(), 1);
        if (got_q.size() > 0) check("blk_resp", got_q[0], BLK_EN ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY);

        // Ordering: slow forwarded write ahead of a blocked one
        set_knobs(100, 100, 100, 10, 0, 0);
        add_wr(32'h1000, 32'hCAFE_0001, 4'hF);
        add_wr(32'h8000, 32'hCAFE_0002, 4'hF);
        got_q.delete();
        drain(100);
        check("order_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("order_first", got_q[0], AXIL_RESP_OKAY);
            check("order_second", got_q[1], BLK_EN ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY);
        end

        // Full queue
        block_mask = 0;
        set_knobs(100, 100, 100, 0, 0, 0);
        b_hold = 1;
        a0 = accepted;
        for (int i = 0; i < MO + 1; i++) add_wr(32'h2000 + 32'(i * 4), $urandom, 4'hF);
        repeat (30) step();
        check("full_outstanding", outstanding, MO);
        check("full_accepted", accepted - a0, MO);
        check("full_awready_low", s_axil_awready, 0);
        b0 = b_issued; b_hold = 0; n = 0;
        while (b_issued == b0 && n < 50) begin
            step();
            n++;
            if (b_issued == b0) check("full_stall", accepted - a0, MO);
        end
        drain(200);
        check("full_all_accepted", accepted - a0, MO + 1);

        // Slave b backpressure
        set_knobs(100, 100, 0, 0, 0, 1);
        add_wr(32'h3000, $urandom, 4'hF);
        add_wr(32'h3004, $urandom, 4'hF);
        repeat (15) step();
        held = s_axil_bresp;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_s_bvalid", s_axil_bvalid, 1);
            check("bp_s_bresp", s_axil_bresp, held);
            check("bp_m_bready", m_axil_bready, 0);
        end
        sb_rdy_pct = 100;
        drain(100);

        // Reset with writes in flight
        b_hold = 1;
        for (int i = 0; i < 3; i++) add_wr(32'h4000 + 32'(i * 4), $urandom, 4'hF);
        repeat (20) step();
        check("pre_rst_outstanding", outstanding, 3);
        do_reset();
        b_hold = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("post_rst_s_bvalid", s_axil_bvalid, 0);
            check("post_rst_outstanding", outstanding, 0);
        end

        // Randomized segments
        for (int seg = 0; seg < 4; seg++) begin
            set_knobs(30 + seg * 20, 40 + seg * 15, 35 + seg * 20, 0, 1, 1);
            mask = (seg == 3) ? 32'h0 : (32'hFFFF_F000 << (4 * seg));
            base = $urandom & mask;
            block_base = base; block_mask = mask;
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(1) == 1)
                    add_wr(((base & mask) | ($urandom & ~mask)) & ~32'h3, $urandom, 4'($urandom_range(15)));
                else
                    add_wr($urandom & ~32'h3, $urandom, 4'($urandom_range(15)));
            end
            drain(5000);
            check("rand_order_empty", order_q.size(), 0);
            check("rand_mresp_empty", mresp_q.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
